mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_extract.sv | 23 ++
 rtl/mem_lsu.sv | 118 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM state type and access-size helpers for mem_lsu.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] t);
    return t[1:0] == 2'b00;
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return t[1:0] == 2'b01;
  endfunction

  // 010, 011, 110 and 111 all behave as word accesses
  function automatic logic is_word(input logic [2:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane select and sign/zero extension of the returned bus word.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [2:0]  lst,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    data    = word;
    if (is_byte(lst)) begin
      data = lst[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half(lst)) begin
      data = lst[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: captures one access in IDLE, runs a single bus transaction,
// and returns lane-extended load data with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for rd_req/wr_req; lse updates the type register
// REQ    | bus_req held with stable addr/be/wdata until bus_gnt
// WAIT_R | load granted, waiting for bus_rvalid
// DONE   | done pulse (with misaligned if the access faulted)
module mem_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lse,
  input  logic [2:0]  lst,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  lsu_state_e  state;
  logic [2:0]  lst_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic        mis_q;

  logic        accept;
  logic [2:0]  lst_eff;
  logic        mis_now;
  logic [31:0] load_data;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes;

  // a type written in the same cycle as the request applies to that request
  assign lst_eff = lse ? lst : lst_q;
  assign accept  = reset_n && (state == IDLE) && (rd_req || wr_req);
  assign mis_now = (is_half(lst_eff) && adr[0]) ||
                   (is_word(lst_eff) && (adr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lst_q   <= LS_W;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lse) lst_q <= lst;
          if (accept) begin
            addr_q  <= adr;
            wdata_q <= wdata;
            store_q <= wr_req;
            mis_q   <= mis_now;
            state   <= mis_now ? DONE : REQ;
          end
        end
        REQ: begin
          if (bus_gnt) state <= store_q ? DONE : WAIT_R;
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            rdata <= load_data;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lsu_extract u_extract (
    .lst  (lst_q),
    .off  (addr_q[1:0]),
    .word (bus_rdata),
    .data (load_data)
  );

  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = wdata_q;
    if (is_byte(lst_q)) begin
      be_lanes    = 4'b0001 << addr_q[1:0];
      wdata_lanes = {4{wdata_q[7:0]}};
    end else if (is_half(lst_q)) begin
      be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{wdata_q[15:0]}};
    end
  end

  assign bus_req    = (state == REQ);
  assign bus_we     = bus_req && store_q;
  assign bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_be     = bus_req ? be_lanes : 4'b0000;
  assign bus_wdata  = bus_we ? wdata_lanes : '0;
  assign done       = (state == DONE);
  assign misaligned = done && mis_q;
  assign busy       = (state != IDLE) || accept;

endmodule
